// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and default constants for the memory-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int C_CNT_W   = 4;
  localparam int C_MEM_LAT = 4;

endpackage

`default_nettype wire

// File: rtl/mem_lat_counter.sv
// ============================================================================
// Module : mem_lat_counter
// Brief  : Memory latency counter; flags the final BUSY cycle, never wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int CNT_W   = C_CNT_W,
  parameter int MEM_LAT = C_MEM_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_hit
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_hit   = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_wait_arbiter.sv
// ============================================================================
// Module : mem_wait_arbiter
// Brief  : Arbitrates the single multi-cycle memory port between I- and
//          D-cache miss handlers. Define MEM_ARB_RR_EN for round-robin on
//          conflict; otherwise D-side has fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wait_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CNT_W   = C_CNT_W,
  parameter int MEM_LAT = C_MEM_LAT,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              wr_d,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              ack_i,
  output logic              ack_d,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_wr;
  logic              w_grant;
  logic              w_pick_d;
  logic              w_prio_d;
  logic              w_hit;
  logic              w_cnt_clear;
  logic              w_cnt_en;

`ifdef MEM_ARB_RR_EN
  // Low means I was granted last; reset value lets D win the first conflict.
  logic r_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_pick_d;
    end
  end

  assign w_prio_d = ~r_last_d;
`else
  assign w_prio_d = 1'b1;
`endif

  assign w_grant  = (r_state == IDLE) && (req_i || req_d);
  assign w_pick_d = req_d && (!req_i || w_prio_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_i || req_d) w_state_nxt = BUSY;
      BUSY:    if (w_hit)          w_state_nxt = ACK;
      ACK:                         w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_NONE;
      r_mem_addr <= '0;
      r_wr       <= 1'b0;
    end else if (w_grant) begin
      r_owner    <= w_pick_d ? OWN_D : OWN_I;
      r_mem_addr <= w_pick_d ? addr_d : addr_i;
      r_wr       <= w_pick_d & wr_d;
    end else if (r_state == ACK) begin
      r_owner    <= OWN_NONE;
    end
  end

  // Counter is held at zero outside BUSY and freezes on its last value.
  assign w_cnt_clear = (r_state != BUSY);
  assign w_cnt_en    = (r_state == BUSY) && !w_hit;

  mem_lat_counter #(
    .CNT_W   (CNT_W),
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_count (count),
    .o_hit   (w_hit)
  );

  assign gnt_i    = (r_owner == OWN_I);
  assign gnt_d    = (r_owner == OWN_D);
  assign ack_i    = (r_state == ACK) && (r_owner == OWN_I);
  assign ack_d    = (r_state == ACK) && (r_owner == OWN_D);
  assign mem_en   = (r_state == BUSY);
  assign mem_wr   = (r_state == BUSY) && (r_owner == OWN_D) && r_wr;
  assign mem_addr = r_mem_addr;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire
